// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: access-size encodings, LSU state and request types.
package mips_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSV  = 2'b11;

  typedef enum logic [1:0] {IDLE, RD, DATA, WR} lsu_state_t;

  // Only the fields needed after the accept cycle; word-store data goes straight out.
  typedef struct packed {
    logic        store;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  off;
    logic [15:0] wdata;
  } lsu_req_t;

  function automatic logic req_fault(input logic [1:0] size, input logic [31:0] addr,
                                     input logic [31:0] memsize);
    return (size == SZ_RSV) ||
           (size == SZ_HALF && addr[0]) ||
           (size == SZ_WORD && addr[1:0] != 2'b00) ||
           (addr >= memsize);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Big-endian lane steering: extract/extend for loads, byte/half merge for sub-word stores.
module lsu_lane
  import mips_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);

  logic [NUM_LANES-1:0][LANE_W-1:0] rl, ml;
  logic [1:0] hi, lo;

  // Offset 0 is the most significant lane; a half occupies lanes hi and hi-1.
  assign hi = 2'd3 - off;
  assign lo = hi - 2'd1;
  assign rl = rdata;

  always_comb begin
    ml    = rl;
    ldata = rdata;
    case (size)
      SZ_BYTE: begin
        ldata  = {{24{sgn & rl[hi][7]}}, rl[hi]};
        ml[hi] = wdata[7:0];
      end
      SZ_HALF: begin
        ldata  = {{16{sgn & rl[hi][7]}}, rl[hi], rl[lo]};
        ml[hi] = wdata[15:8];
        ml[lo] = wdata[7:0];
      end
      default: ;
    endcase
  end

  assign mdata = ml;

endmodule

// File: rtl/lsu.sv
// Load/store unit: alignment/bounds checks and word-granular access sequencing to data memory.
module lsu
  import mips_pkg::*;
#(
  parameter int MEMSIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state;
  lsu_req_t    req_q;
  logic        fault;
  logic [31:0] ldata, mdata;

  assign fault = req_fault(req_size, req_addr, 32'(MEMSIZE));

  lsu_lane u_lane (
    .off   (req_q.off),
    .size  (req_q.size),
    .sgn   (req_q.sgn),
    .rdata (mem_rdata),
    .wdata (req_q.wdata),
    .ldata (ldata),
    .mdata (mdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      case (state)
        IDLE: if (req_valid) begin
          req_q.store <= req_store;
          req_q.size  <= req_size;
          req_q.sgn   <= req_signed;
          req_q.off   <= req_addr[1:0];
          req_q.wdata <= req_wdata[15:0];
          if (fault) begin
            resp_valid <= 1'b1;
            resp_fault <= 1'b1;
          end else begin
            mem_addr  <= {req_addr[31:2], 2'b00};
            req_ready <= 1'b0;
            if (req_store && req_size == SZ_WORD) begin
              mem_write <= 1'b1;
              mem_wdata <= req_wdata;
              state     <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: state <= DATA;
        // mem_rdata now reflects the word addressed two edges ago
        DATA: if (req_q.store) begin
          mem_wdata <= mdata;
          mem_write <= 1'b1;
          state     <= WR;
        end else begin
          resp_valid <= 1'b1;
          resp_rdata <= ldata;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        WR: begin
          mem_write  <= 1'b0;
          resp_valid <= 1'b1;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
